// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_SETUP,
    ST_PULSE,
    ST_WAIT,
    ST_IDLE
  } state_e;

  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] HOME      = 8'h02;
  localparam logic [7:0] FUNC_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] ENTRY_INC = 8'h06;

  localparam int unsigned INIT_LEN = 4;
  localparam int unsigned INIT_IW  = 2;

  localparam logic [7:0] INIT_TABLE [INIT_LEN] = '{FUNC_8B2L, DISP_ON, CLEAR, ENTRY_INC};

  // Clear and both return-home encodings need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (!rs) && ((data == CLEAR) || (data == HOME) || (data == (CLEAR | HOME)));
  endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter; done_o is high during the last cycle of a loaded interval.
module lcd_delay_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         done_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= (cnt_d == W'(1));
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write-only controller: power-up delay, fixed init table, then
// handshaked command/data writes with setup, enable pulse and execution wait.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP_CYC = 750000,
  parameter int unsigned T_SETUP_CYC = 2,
  parameter int unsigned T_EN_CYC    = 12,
  parameter int unsigned T_CMD_CYC   = 2000,
  parameter int unsigned T_CLR_CYC   = 82000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req_vld,
  output logic       o_req_rdy,
  input  logic       i_req_rs,
  input  logic [7:0] i_req_data,
  output logic       o_busy,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);

  localparam int unsigned MAX_A   = (T_PWRUP_CYC > T_SETUP_CYC) ? T_PWRUP_CYC : T_SETUP_CYC;
  localparam int unsigned MAX_B   = (T_EN_CYC > T_CMD_CYC) ? T_EN_CYC : T_CMD_CYC;
  localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CYC = (MAX_C > T_CLR_CYC) ? MAX_C : T_CLR_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

  if ((T_PWRUP_CYC == 0) || (T_SETUP_CYC == 0) || (T_EN_CYC == 0) ||
      (T_CMD_CYC == 0) || (T_CLR_CYC == 0)) begin : g_bad_param
    $error("lcd_ctrl: every timing parameter must be at least 1");
  end

  state_e              state_q, state_d;
  logic [INIT_IW-1:0]  idx_q, idx_d;
  logic                rs_q, rs_d;
  logic [7:0]          data_q, data_d;
  logic                init_done_q, init_done_d;
  logic                on_q;
  logic                en_q;
  logic                rdy_q;
  logic                busy_q;
  logic                cnt_load;
  logic [CW-1:0]       cnt_val;
  logic                cnt_done;

  lcd_delay_cnt #(.W(CW)) u_delay (
    .clk_i   (i_clk),
    .reset_i (i_reset),
    .load_i  (cnt_load),
    .value_i (cnt_val),
    .done_o  (cnt_done)
  );

  // Next-state, pin latching and delay-counter loads.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rs_d        = rs_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    unique case (state_q)
      ST_PWRUP: begin
        if (!on_q) begin
          // First edge out of reset starts the power-up interval.
          cnt_load = 1'b1;
          cnt_val  = CW'(T_PWRUP_CYC);
        end else if (cnt_done) begin
          state_d  = ST_SETUP;
          idx_d    = '0;
          rs_d     = 1'b0;
          data_d   = INIT_TABLE[0];
          cnt_load = 1'b1;
          cnt_val  = CW'(T_SETUP_CYC);
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          state_d  = ST_PULSE;
          cnt_load = 1'b1;
          cnt_val  = CW'(T_EN_CYC);
        end
      end
      ST_PULSE: begin
        if (cnt_done) begin
          state_d  = ST_WAIT;
          cnt_load = 1'b1;
          cnt_val  = is_long_cmd(rs_q, data_q) ? CW'(T_CLR_CYC) : CW'(T_CMD_CYC);
        end
      end
      ST_WAIT: begin
        if (cnt_done) begin
          if (!init_done_q && (idx_q != INIT_IW'(INIT_LEN - 1))) begin
            state_d  = ST_SETUP;
            idx_d    = idx_q + INIT_IW'(1);
            rs_d     = 1'b0;
            data_d   = INIT_TABLE[idx_q + INIT_IW'(1)];
            cnt_load = 1'b1;
            cnt_val  = CW'(T_SETUP_CYC);
          end else begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (i_req_vld && rdy_q) begin
          state_d  = ST_SETUP;
          rs_d     = i_req_rs;
          data_d   = i_req_data;
          cnt_load = 1'b1;
          cnt_val  = CW'(T_SETUP_CYC);
        end
      end
      default: begin
        state_d = ST_PWRUP;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_PWRUP;
      idx_q       <= '0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      init_done_q <= 1'b0;
      on_q        <= 1'b0;
      en_q        <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
      on_q        <= 1'b1;
      en_q        <= (state_d == ST_PULSE);
      rdy_q       <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign o_req_rdy   = rdy_q;
  assign o_busy      = busy_q;
  assign o_init_done = init_done_q;
  assign o_lcd_on    = on_q;
  assign o_lcd_en    = en_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed + randomized bench for lcd_ctrl against a timing/behaviour model.
module tb_lcd_ctrl;

  localparam int unsigned P_PWRUP = 10;
  localparam int unsigned P_SETUP = 2;
  localparam int unsigned P_EN    = 3;
  localparam int unsigned P_CMD   = 5;
  localparam int unsigned P_CLR   = 8;

  logic       i_clk, i_reset, i_req_vld, i_req_rs;
  logic [7:0] i_req_data;
  logic       o_req_rdy, o_busy, o_init_done, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
  logic [7:0] o_lcd_data;

  lcd_ctrl #(
    .T_PWRUP_CYC (P_PWRUP),
    .T_SETUP_CYC (P_SETUP),
    .T_EN_CYC    (P_EN),
    .T_CMD_CYC   (P_CMD),
    .T_CLR_CYC   (P_CLR)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req_vld   (i_req_vld),
    .o_req_rdy   (o_req_rdy),
    .i_req_rs    (i_req_rs),
    .i_req_data  (i_req_data),
    .o_busy      (o_busy),
    .o_init_done (o_init_done),
    .o_lcd_on    (o_lcd_on),
    .o_lcd_en    (o_lcd_en),
    .o_lcd_rs    (o_lcd_rs),
    .o_lcd_rw    (o_lcd_rw),
    .o_lcd_data  (o_lcd_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  always @(posedge i_clk) edge_n <= edge_n + 1;

  typedef struct {
    logic [7:0] d;
    logic       rs;
    int         start;
    int         width;
  } pulse_t;

  pulse_t pq[$];
  pulse_t cur;
  logic   en_prev = 1'b0;

  // Records every EN pulse: pins at rise, rising edge number, width in cycles.
  always @(negedge i_clk) begin
    if (o_lcd_en === 1'b1 && !en_prev) begin
      cur.d     = o_lcd_data;
      cur.rs    = o_lcd_rs;
      cur.start = edge_n;
      cur.width = 0;
    end
    if (o_lcd_en === 1'b1) cur.width = cur.width + 1;
    if (o_lcd_en !== 1'b1 && en_prev) pq.push_back(cur);
    en_prev = (o_lcd_en === 1'b1);
  end

  // Reference model: execution wait and busy window derived from the command rules.
  function automatic int exec_model(input logic rs, input logic [7:0] d);
    if (rs == 1'b0 && d >= 8'h01 && d <= 8'h03) return P_CLR;
    return P_CMD;
  endfunction

  function automatic int busy_model(input logic rs, input logic [7:0] d);
    return P_SETUP + P_EN + exec_model(rs, d);
  endfunction

  logic [7:0] init_ref [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  function automatic int init_model();
    int t = P_PWRUP;
    for (int i = 0; i < 4; i++) t += P_SETUP + P_EN + exec_model(1'b0, init_ref[i]);
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"},  32'(o_req_rdy),   32'd0);
    chk({tag, "_busy"}, 32'(o_busy),      32'd1);
    chk({tag, "_done"}, 32'(o_init_done), 32'd0);
    chk({tag, "_on"},   32'(o_lcd_on),    32'd0);
    chk({tag, "_en"},   32'(o_lcd_en),    32'd0);
    chk({tag, "_rs"},   32'(o_lcd_rs),    32'd0);
    chk({tag, "_rw"},   32'(o_lcd_rw),    32'd0);
    chk({tag, "_data"}, 32'(o_lcd_data),  32'd0);
  endtask

  // Release reset (called at a negedge) and verify the init sequence and latency.
  task automatic measure_init(input string tag);
    int c;
    int first_rdy;
    logic found;
    c = 0; first_rdy = -1; found = 1'b0;
    pq.delete();
    i_reset = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (k == 0) chk({tag, "_on_cyc0"}, 32'(o_lcd_on), 32'd1);
      if (o_req_rdy === 1'b1 && first_rdy < 0) first_rdy = k;
      if (o_init_done === 1'b1) begin
        found = 1'b1;
        c = k;
      end
    end
    chk({tag, "_done_cyc"}, 32'(found ? c : -1), 32'(init_model()));
    chk({tag, "_rdy_cyc"}, 32'(first_rdy), 32'(init_model()));
    chk({tag, "_busy_lo"}, 32'(o_busy), 32'd0);
    chk({tag, "_npulse"}, 32'(pq.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < pq.size()) begin
        chk({tag, "_init_data"}, {23'd0, pq[i].rs, pq[i].d}, {24'd0, init_ref[i]});
        chk({tag, "_init_width"}, 32'(pq[i].width), 32'(P_EN));
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_req_rdy !== 1'b1 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    chk({tag, "_idle"}, 32'(o_req_rdy), 32'd1);
  endtask

  // Single write from IDLE, checked for pins, busy length, hold and pulse timing.
  task automatic do_write(input string tag, input logic rs, input logic [7:0] d);
    int acc, n;
    logic stable;
    pq.delete();
    i_req_vld = 1'b1; i_req_rs = rs; i_req_data = d;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_vld = 1'b0;
    i_req_data = ~d;
    acc = edge_n;
    chk({tag, "_pins"}, {23'd0, o_lcd_rs, o_lcd_data}, {23'd0, rs, d});
    n = 0; stable = 1'b1;
    while (o_req_rdy !== 1'b1 && n < 200) begin
      if ({o_lcd_rs, o_lcd_data} !== {rs, d} || o_busy !== 1'b1) stable = 1'b0;
      @(negedge i_clk);
      n++;
    end
    chk({tag, "_busy_len"}, 32'(n), 32'(busy_model(rs, d)));
    chk({tag, "_hold"}, 32'(stable), 32'd1);
    chk({tag, "_npulse"}, 32'(pq.size()), 32'd1);
    if (pq.size() > 0) begin
      chk({tag, "_pdata"}, {23'd0, pq[0].rs, pq[0].d}, {23'd0, rs, d});
      chk({tag, "_pwidth"}, 32'(pq[0].width), 32'(P_EN));
      chk({tag, "_pstart"}, 32'(pq[0].start - acc), 32'(P_SETUP));
    end
  endtask

  initial begin
    int acc, n, cnt42, c;
    logic rs;
    logic [7:0] d;
    i_reset = 1'b1; i_req_vld = 1'b0; i_req_rs = 1'b0; i_req_data = 8'h00;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk_reset_vals("rst");

    // Reset release and automatic init
    measure_init("init");

    // Directed writes: data, clear, home variants, boundary bytes
    do_write("wr41", 1'b1, 8'h41);
    do_write("clr", 1'b0, 8'h01);
    do_write("home3", 1'b0, 8'h03);
    do_write("cmd04", 1'b0, 8'h04);
    do_write("dat01", 1'b1, 8'h01);

    // Held request raised during WAIT of a previous write
    pq.delete();
    i_req_vld = 1'b1; i_req_rs = 1'b1; i_req_data = 8'h55;
    @(posedge i_clk);
    @(negedge i_clk);
    acc = edge_n;
    i_req_vld = 1'b0;
    repeat (P_SETUP + P_EN + 1) @(negedge i_clk);
    i_req_vld = 1'b1; i_req_rs = 1'b1; i_req_data = 8'h42;
    n = 0;
    while (o_req_rdy !== 1'b1 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    chk("held_rdy_edge", 32'(edge_n - acc), 32'(busy_model(1'b1, 8'h55)));
    chk("held_pins_before", {23'd0, o_lcd_rs, o_lcd_data}, {23'd0, 1'b1, 8'h55});
    chk("held_npulse_before", 32'(pq.size()), 32'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_vld = 1'b0;
    chk("held_pins_after", {23'd0, o_lcd_rs, o_lcd_data}, {23'd0, 1'b1, 8'h42});
    wait_idle("held");
    cnt42 = 0;
    foreach (pq[i]) if (pq[i].d == 8'h42) cnt42++;
    chk("held_npulse", 32'(pq.size()), 32'd2);
    chk("held_one42", 32'(cnt42), 32'd1);

    // Back-to-back with vld held high
    pq.delete();
    i_req_vld = 1'b1; i_req_rs = 1'b1; i_req_data = 8'h48;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_data = 8'h49;
    n = 0;
    while (o_req_rdy !== 1'b1 && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_vld = 1'b0;
    wait_idle("b2b");
    chk("b2b_npulse", 32'(pq.size()), 32'd2);
    if (pq.size() >= 2) begin
      chk("b2b_d0", 32'(pq[0].d), 32'h48);
      chk("b2b_d1", 32'(pq[1].d), 32'h49);
      chk("b2b_spacing", 32'(pq[1].start - pq[0].start), 32'(busy_model(1'b1, 8'h48) + 1));
    end

    // Randomized writes, biased toward the long-wait boundary bytes
    for (int k = 0; k < 8; k++) begin
      rs = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      do_write("rand", rs, d);
    end

    // Reset while EN is high
    i_req_vld = 1'b1; i_req_rs = 1'b1; i_req_data = 8'h5A;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_vld = 1'b0;
    c = 0;
    while (o_lcd_en !== 1'b1 && c < 50) begin
      @(negedge i_clk);
      c++;
    end
    chk("mid_en_seen", 32'(o_lcd_en), 32'd1);
    i_reset = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    chk_reset_vals("midrst");
    @(posedge i_clk);
    @(negedge i_clk);
    measure_init("reinit");
    do_write("post", 1'b1, 8'h7E);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
